eth_link_monitor: RTL and testbench
===================================

ETH_LINK_MONITOR -- requirements
Module: eth_link_monitor

Interface
REQ-001 SHALL have parameter REF_CLK, default 50, clk frequency in MHz.
REQ-002 SHALL have parameter STABLE_US, default 10000, qualification window in microseconds; window N = REF_CLK*STABLE_US cycles, N >= 2.
REQ-003 SHALL have parameter MAC_RST_CYC, default 16, MAC reset hold after link-up, >= 1.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port phy_link  input  1  raw link from the MDIO poller.
REQ-007 SHALL have port phy_speed  input  2  raw speed from the MDIO poller: 00 10M, 01 100M, 10 1000M, 11 invalid.
REQ-008 SHALL have port link_up  output  1  qualified link.
REQ-009 SHALL have port mac_speed  output  2  speed latched at qualification, stable while link_up=1.
REQ-010 SHALL have port link_event  output  1  one-cycle pulse on each link_up edge.
REQ-011 SHALL have port mac_rst  output  1  active-high MAC datapath reset.
REQ-012 SHALL have port flap_cnt  output  8  saturating count of link losses.

Function
REQ-013 SHALL register phy_link/phy_speed once; all decisions use registered values; "valid" = link 1 and speed != 11.
REQ-014 SHALL implement states DOWN, QUAL_UP, UP, QUAL_DOWN with a window timer wide enough for N.
REQ-015 DOWN: timer 0; valid -> QUAL_UP.
REQ-016 QUAL_UP: timer counts while valid and speed equals the speed captured on entry; link 0 or speed 11 -> DOWN; different valid speed -> restart timer, recapture speed; N consecutive cycles -> UP, latch mac_speed.
REQ-017 link_up SHALL rise exactly N+1 edges after the edge first sampling valid, stable inputs.
REQ-018 UP: link 0, speed 11, or speed != mac_speed -> QUAL_DOWN, timer cleared.
REQ-019 QUAL_DOWN: link_up stays 1; registered input valid with speed == mac_speed -> UP without event; fault held N consecutive cycles -> DOWN, link_up 0.
REQ-020 link_event SHALL pulse in the cycle after each link_up change, in both directions.
REQ-021 mac_rst SHALL be 1 whenever link_up=0 and for exactly MAC_RST_CYC cycles after link_up rises; a loss during hold keeps it 1.
REQ-022 flap_cnt SHALL increment on each QUAL_DOWN -> DOWN transition and saturate at 255.
REQ-023 mac_speed SHALL hold its last value after link loss until the next qualification.

Reset
REQ-024 rst SHALL force state DOWN, timers 0, link_up 0, mac_speed 00, link_event 0, mac_rst 1, flap_cnt 0, input registers 0.
REQ-025 rst mid-qualification or while UP SHALL abort without link_event and without incrementing flap_cnt.

Configuration
REQ-026 With LINK_FLAP_CNT_EN defined, flap_cnt SHALL behave per REQ-022; without it, flap_cnt SHALL be constant 0 and no counter logic SHALL be built.

Structure
REQ-027 Speed encodings (10M/100M/1000M/invalid) and state encoding SHALL live in shared package eth_pkg.
REQ-028 Window timer SHALL be a sub-module eth_stable_timer (clear, enable, done at N).

Verification (REF_CLK=1, STABLE_US=8, N=8, MAC_RST_CYC=4)
REQ-029 From reset, phy_link=1, phy_speed=10 held -> link_up=1 after 9 edges, link_event 1 cycle, mac_speed=10, mac_rst low 4 cycles later.
REQ-030 While UP, phy_link=0 for 5 cycles then 1 -> link_up stays 1, no link_event, flap_cnt unchanged.
REQ-031 While UP, phy_speed 10 -> 01 held -> link_up drops after N cycles, flap_cnt +1, then re-qualifies with mac_speed=01 after N+1 more.
REQ-032 During QUAL_UP, phy_speed=11 on cycle 4 -> state DOWN, link_up stays 0; restore -> full N window restarts.
REQ-033 Toggle link down/up 260 times -> flap_cnt saturates at 255 (255 fixed at 0 without LINK_FLAP_CNT_EN); rst asserted while UP -> link_up 0, mac_rst 1, no link_event.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared encodings for the Ethernet link monitor: PHY speed codes and monitor states.
package eth_pkg;

  typedef enum logic [1:0] {
    Speed10M     = 2'b00,
    Speed100M    = 2'b01,
    Speed1000M   = 2'b10,
    SpeedInvalid = 2'b11
  } eth_speed_e;

  typedef enum logic [1:0] {
    StDown     = 2'b00,
    StQualUp   = 2'b01,
    StUp       = 2'b10,
    StQualDown = 2'b11
  } eth_state_e;

  function automatic logic link_valid(input logic link, input eth_speed_e speed);
    return link && (speed != SpeedInvalid);
  endfunction

endpackage

// File: rtl/eth_stable_timer.sv
// Qualification window timer: counts enabled cycles, clears on demand.
// done_o flags that the current cycle, if counted, is the N-th consecutive one.
module eth_stable_timer #(
  parameter int unsigned N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] Last = CntW'(N - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/eth_link_monitor.sv
// Debounces the MDIO-polled PHY link/speed into a qualified link with MAC reset control.
// Define LINK_FLAP_CNT_EN to build the saturating link-loss counter on flap_cnt.
module eth_link_monitor
  import eth_pkg::*;
#(
  parameter int unsigned REF_CLK     = 50,
  parameter int unsigned STABLE_US   = 10000,
  parameter int unsigned MAC_RST_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       phy_link,
  input  logic [1:0] phy_speed,
  output logic       link_up,
  output logic [1:0] mac_speed,
  output logic       link_event,
  output logic       mac_rst,
  output logic [7:0] flap_cnt
);

  localparam int unsigned WinN  = REF_CLK * STABLE_US;
  localparam int unsigned HoldW = $clog2(MAC_RST_CYC + 1);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(MAC_RST_CYC);

  logic             phy_link_q;
  eth_speed_e       phy_speed_q;
  eth_state_e       state_q, state_d;
  eth_speed_e       cap_q, cap_d;
  eth_speed_e       mac_speed_q, mac_speed_d;
  logic             tmr_clr, tmr_en, tmr_done;
  logic             in_valid, in_match;
  logic             link_up_d;
  logic             link_prev_q, link_event_q;
  logic [HoldW-1:0] hold_q, hold_d;

  assign in_valid = link_valid(phy_link_q, phy_speed_q);
  assign in_match = in_valid && (phy_speed_q == mac_speed_q);

  eth_stable_timer #(
    .N(WinN)
  ) u_timer (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .done_o(tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    mac_speed_d = mac_speed_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    case (state_q)
      StDown: begin
        tmr_clr = 1'b1;
        if (in_valid) begin
          state_d = StQualUp;
          cap_d   = phy_speed_q;
        end
      end
      StQualUp: begin
        if (!in_valid) begin
          state_d = StDown;
          tmr_clr = 1'b1;
        end else if (phy_speed_q != cap_q) begin
          // A new valid speed restarts qualification from scratch.
          cap_d   = phy_speed_q;
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          state_d     = StUp;
          mac_speed_d = cap_q;
          tmr_clr     = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StUp: begin
        tmr_clr = 1'b1;
        if (!in_match) begin
          state_d = StQualDown;
        end
      end
      StQualDown: begin
        if (in_match) begin
          state_d = StUp;
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          state_d = StDown;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_d = StDown;
        tmr_clr = 1'b1;
      end
    endcase
  end

  assign link_up   = (state_q == StUp) || (state_q == StQualDown);
  assign link_up_d = (state_d == StUp) || (state_d == StQualDown);

  always_comb begin
    hold_d = hold_q;
    if (!link_up_d) begin
      hold_d = '0;
    end else if (!link_up) begin
      hold_d = HoldInit;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HoldW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phy_link_q   <= 1'b0;
      phy_speed_q  <= Speed10M;
      state_q      <= StDown;
      cap_q        <= Speed10M;
      mac_speed_q  <= Speed10M;
      link_prev_q  <= 1'b0;
      link_event_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      phy_link_q   <= phy_link;
      phy_speed_q  <= eth_speed_e'(phy_speed);
      state_q      <= state_d;
      cap_q        <= cap_d;
      mac_speed_q  <= mac_speed_d;
      link_prev_q  <= link_up;
      link_event_q <= link_up ^ link_prev_q;
      hold_q       <= hold_d;
    end
  end

  assign mac_speed  = mac_speed_q;
  assign link_event = link_event_q;
  assign mac_rst    = !link_up || (hold_q != '0);

`ifdef LINK_FLAP_CNT_EN
  logic [7:0] flap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flap_q <= 8'd0;
    end else if ((state_q == StQualDown) && (state_d == StDown) && (flap_q != 8'hFF)) begin
      flap_q <= flap_q + 8'd1;
    end
  end

  assign flap_cnt = flap_q;
`else
  assign flap_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_eth_link_monitor.sv
// Self-checking bench for eth_link_monitor: directed table, corner sequences, random vs run-length model.
module tb_eth_link_monitor;

  localparam int N = 8;
  localparam int M = 4;

  logic       clk;
  logic       rst;
  logic       phy_link;
  logic [1:0] phy_speed;
  logic       link_up;
  logic [1:0] mac_speed;
  logic       link_event;
  logic       mac_rst;
  logic [7:0] flap_cnt;

  int total;
  int bad;

  // Reference model: qualification by run lengths of consecutive samples.
  bit       m_link_r;
  bit [1:0] m_speed_r;
  bit       m_up, m_up_prev, m_ev;
  bit [1:0] m_mspeed, m_rspeed;
  int       m_run, m_bad, m_since, m_flap;

  typedef struct {
    logic       link;
    logic [1:0] speed;
    int         cycles;
    logic       up;
    logic [1:0] mspeed;
    int         flap;
  } vec_t;

  vec_t vt[9];

  eth_link_monitor #(
    .REF_CLK    (1),
    .STABLE_US  (8),
    .MAC_RST_CYC(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .phy_link  (phy_link),
    .phy_speed (phy_speed),
    .link_up   (link_up),
    .mac_speed (mac_speed),
    .link_event(link_event),
    .mac_rst   (mac_rst),
    .flap_cnt  (flap_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int flap_exp(input int f);
`ifdef LINK_FLAP_CNT_EN
    return f;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit v;
    if (rst) begin
      m_link_r = 0; m_speed_r = 0; m_up = 0; m_up_prev = 0; m_ev = 0;
      m_mspeed = 0; m_rspeed = 0; m_run = 0; m_bad = 0; m_since = 0; m_flap = 0;
      return;
    end
    m_ev      = (m_up != m_up_prev);
    m_up_prev = m_up;
    v = m_link_r && (m_speed_r != 2'b11);
    if (!m_up) begin
      if (v) begin
        if (m_run > 0 && m_speed_r == m_rspeed) m_run++;
        else begin
          m_run    = 1;
          m_rspeed = m_speed_r;
        end
      end else begin
        m_run = 0;
      end
      if (m_run == N + 1) begin
        m_up     = 1;
        m_mspeed = m_rspeed;
        m_bad    = 0;
        m_since  = 0;
      end
    end else begin
      if (v && m_speed_r == m_mspeed) m_bad = 0;
      else m_bad++;
      if (m_bad == N + 1) begin
        m_up  = 0;
        m_run = 0;
        if (m_flap < 255) m_flap++;
      end else if (m_since < 1000) begin
        m_since++;
      end
    end
    m_link_r  = phy_link;
    m_speed_r = phy_speed;
  endtask

  task automatic cycle();
    logic [12:0] act, exp;
    @(posedge clk);
    model_edge();
    #1;
    act = {link_up, mac_speed, link_event, mac_rst, flap_cnt};
    exp = {m_up, m_mspeed, m_ev, (!m_up || m_since < M), 8'(flap_exp(m_flap))};
    check("outputs{up,spd,ev,mrst,flap}", int'(act), int'(exp));
  endtask

  initial begin
    int rise_c, ev_c, ev_n, fall_c;
    total = 0;
    bad   = 0;
    rst = 1'b1; phy_link = 1'b0; phy_speed = 2'b00;
    cycle();
    cycle();
    check("reset link_up", int'(link_up), 0);
    check("reset mac_rst", int'(mac_rst), 1);
    check("reset mac_speed", int'(mac_speed), 0);
    check("reset link_event", int'(link_event), 0);
    check("reset flap_cnt", int'(flap_cnt), 0);

    // Qualification latency from reset with 1000M held.
    rst = 1'b0; phy_link = 1'b1; phy_speed = 2'b10;
    rise_c = 0; ev_c = 0; ev_n = 0; fall_c = 0;
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (link_up && rise_c == 0) rise_c = c;
      if (link_event) begin
        ev_n++;
        if (ev_c == 0) ev_c = c;
      end
      if (rise_c != 0 && !mac_rst && fall_c == 0) fall_c = c;
    end
    check("link_up rise edge", rise_c, 10);
    check("link_event edge", ev_c, 11);
    check("link_event count", ev_n, 1);
    check("mac_rst release edge", fall_c, 14);
    check("mac_speed after qual", int'(mac_speed), 2);

    vt[0] = '{1'b1, 2'b10, 5,  1'b1, 2'b10, 0};
    vt[1] = '{1'b0, 2'b10, 5,  1'b1, 2'b10, 0};
    vt[2] = '{1'b1, 2'b10, 6,  1'b1, 2'b10, 0};
    vt[3] = '{1'b1, 2'b01, 20, 1'b1, 2'b01, 1};
    vt[4] = '{1'b1, 2'b11, 12, 1'b0, 2'b01, 2};
    vt[5] = '{1'b1, 2'b10, 3,  1'b0, 2'b01, 2};
    vt[6] = '{1'b1, 2'b11, 1,  1'b0, 2'b01, 2};
    vt[7] = '{1'b1, 2'b10, 9,  1'b0, 2'b01, 2};
    vt[8] = '{1'b1, 2'b10, 1,  1'b1, 2'b10, 2};
    for (int i = 0; i < 9; i++) begin
      phy_link  = vt[i].link;
      phy_speed = vt[i].speed;
      repeat (vt[i].cycles) cycle();
      check($sformatf("vec%0d link_up", i), int'(link_up), int'(vt[i].up));
      check($sformatf("vec%0d mac_speed", i), int'(mac_speed), int'(vt[i].mspeed));
      check($sformatf("vec%0d flap_cnt", i), int'(flap_cnt), flap_exp(vt[i].flap));
    end

    // Repeated link loss drives the flap counter into saturation.
    for (int i = 0; i < 260; i++) begin
      phy_link = 1'b0;
      repeat (12) cycle();
      phy_link = 1'b1; phy_speed = 2'b10;
      repeat (12) cycle();
    end
    check("flap saturated", int'(flap_cnt), flap_exp(255));
    check("up after toggles", int'(link_up), 1);

    // Reset while up: drop silently.
    rst = 1'b1;
    cycle();
    check("rst-up link_up", int'(link_up), 0);
    check("rst-up mac_rst", int'(mac_rst), 1);
    check("rst-up flap_cnt", int'(flap_cnt), 0);
    rst = 1'b0;
    cycle();
    check("rst-up no event", int'(link_event), 0);
    cycle();
    check("rst-up no late event", int'(link_event), 0);

    // Random segments of held inputs with occasional resets.
    for (int s = 0; s < 400; s++) begin
      phy_link  = ($urandom_range(0, 7) != 0);
      phy_speed = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rst       = ($urandom_range(0, 39) == 0);
      cycle();
      rst = 1'b0;
      repeat ($urandom_range(0, 14)) cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
